// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between the
// instruction-fetch port and the data port, with at most one read outstanding.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ready,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_ready,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    m_en,
    output logic                    m_we,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner_d;
    logic       w_owner_d_nxt;
    logic       r_prio_d;
    logic       w_prio_d_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_grant_d;
    logic       w_grant_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_prio_d  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner_d <= w_owner_d_nxt;
            r_prio_d  <= w_prio_d_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Outputs are qualified by reset so that every port reads 0 while reset
    // is held low, even though ready is otherwise combinational on the requests.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_d_nxt = r_owner_d;
        w_prio_d_nxt  = r_prio_d;
        w_cnt_nxt     = r_cnt;
        w_grant_d     = 1'b0;
        w_grant_i     = 1'b0;

        i_ready  = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_ready  = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_wmask  = '0;
        m_addr   = '0;
        m_wdata  = '0;

        if (reset) begin
            case (r_state)
                ST_IDLE: begin
                    w_grant_d = d_req && (!i_req || r_prio_d);
                    w_grant_i = i_req && !w_grant_d;
                    if (w_grant_d) begin
                        d_ready      = 1'b1;
                        m_en         = 1'b1;
                        m_we         = d_we;
                        m_wmask      = d_wmask;
                        m_addr       = d_addr;
                        m_wdata      = d_wdata;
                        w_prio_d_nxt = 1'b0;
                        if (!d_we) begin
                            w_owner_d_nxt = 1'b1;
                            w_cnt_nxt     = 2'(RAM_LATENCY - 1);
                            w_state_nxt   = ST_BUSY;
                        end
                    end else if (w_grant_i) begin
                        i_ready       = 1'b1;
                        m_en          = 1'b1;
                        m_addr        = i_addr;
                        w_prio_d_nxt  = 1'b1;
                        w_owner_d_nxt = 1'b0;
                        w_cnt_nxt     = 2'(RAM_LATENCY - 1);
                        w_state_nxt   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 2'd0) begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end else begin
                        if (r_owner_d) begin
                            d_rvalid = 1'b1;
                            d_rdata  = m_rdata;
                        end else begin
                            i_rvalid = 1'b1;
                            i_rdata  = m_rdata;
                        end
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RAM latency 1 and 3) checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]       i_req, i_ready, i_rvalid;
    logic [1:0][31:0] i_addr, i_rdata;
    logic [1:0]       d_req, d_we, d_ready, d_rvalid;
    logic [1:0][3:0]  d_wmask, m_wmask;
    logic [1:0][31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]       m_en, m_we;
    logic [1:0][31:0] m_addr, m_wdata, m_rdata;

    logic [31:0] mem  [2][64] = '{default: '0};
    logic [31:0] pipe [2][4]  = '{default: '0};

    // reference model state
    logic [31:0] mref [2][64] = '{default: '0};
    logic        pend [2];
    logic        own_d[2];
    logic        fav_d[2];
    int          due  [2];
    logic [31:0] rdat [2];
    logic        acc_i[2];
    logic        acc_d[2];
    logic [31:0] last_i[2];
    logic [31:0] last_d[2];
    logic [7:0]  ord_q[2][$];
    int          cyc;
    int          total;
    int          bad;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(LAT0)) dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ready(i_ready[0]),
        .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_wmask(d_wmask[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_ready(d_ready[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_wmask(m_wmask[0]), .m_addr(m_addr[0]),
        .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0])
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ready(i_ready[1]),
        .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_wmask(d_wmask[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_ready(d_ready[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_wmask(m_wmask[1]), .m_addr(m_addr[1]),
        .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1])
    );

    // RAM behind each arbiter; read data appears LAT cycles after m_en
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
            pipe[k][0] <= (m_en[k] && !m_we[k]) ? mem[k][m_addr[k][5:0]] : '0;
            if (m_en[k] && m_we[k])
                for (int b = 0; b < 4; b++)
                    if (m_wmask[k][b]) mem[k][m_addr[k][5:0]][8*b +: 8] <= m_wdata[k][8*b +: 8];
        end
    end
    assign m_rdata[0] = pipe[0][LAT0-1];
    assign m_rdata[1] = pipe[1][LAT1-1];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // One negedge: predict every output from the model, compare, then
    // advance the model by what the coming posedge commits.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic        e_ir, e_dr, e_iv, e_dv, e_en, e_we, gd, gi;
            logic [3:0]  e_msk;
            logic [31:0] e_ma, e_mwd, e_ird, e_drd;
            int          idx;
            {e_ir, e_dr, e_iv, e_dv, e_en, e_we} = '0;
            e_msk = '0; e_ma = '0; e_mwd = '0; e_ird = '0; e_drd = '0;
            acc_i[k] = 1'b0;
            acc_d[k] = 1'b0;
            if (!reset) begin
                pend[k]  = 1'b0;
                fav_d[k] = 1'b1;
            end else if (pend[k]) begin
                if (cyc == due[k]) begin
                    if (own_d[k]) begin e_dv = 1'b1; e_drd = rdat[k]; end
                    else          begin e_iv = 1'b1; e_ird = rdat[k]; end
                    pend[k] = 1'b0;
                end
            end else begin
                gd = d_req[k] && (!i_req[k] || fav_d[k]);
                gi = i_req[k] && !gd;
                if (gd) begin
                    e_dr = 1'b1; e_en = 1'b1; e_we = d_we[k]; e_msk = d_wmask[k];
                    e_ma = d_addr[k]; e_mwd = d_wdata[k];
                    acc_d[k] = 1'b1; fav_d[k] = 1'b0;
                    idx = int'(d_addr[k][5:0]);
                    if (d_we[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (d_wmask[k][b]) mref[k][idx][8*b +: 8] = d_wdata[k][8*b +: 8];
                    end else begin
                        pend[k] = 1'b1; own_d[k] = 1'b1; due[k] = cyc + lat_of(k);
                        rdat[k] = mref[k][idx];
                    end
                end else if (gi) begin
                    e_ir = 1'b1; e_en = 1'b1; e_ma = i_addr[k];
                    acc_i[k] = 1'b1; fav_d[k] = 1'b1;
                    pend[k] = 1'b1; own_d[k] = 1'b0; due[k] = cyc + lat_of(k);
                    rdat[k] = mref[k][int'(i_addr[k][5:0])];
                end
            end
            check_eq($sformatf("i_ready/%0d", k),  32'(i_ready[k]),  32'(e_ir));
            check_eq($sformatf("d_ready/%0d", k),  32'(d_ready[k]),  32'(e_dr));
            check_eq($sformatf("i_rvalid/%0d", k), 32'(i_rvalid[k]), 32'(e_iv));
            check_eq($sformatf("d_rvalid/%0d", k), 32'(d_rvalid[k]), 32'(e_dv));
            check_eq($sformatf("i_rdata/%0d", k),  i_rdata[k],       e_ird);
            check_eq($sformatf("d_rdata/%0d", k),  d_rdata[k],       e_drd);
            check_eq($sformatf("m_en/%0d", k),     32'(m_en[k]),     32'(e_en));
            check_eq($sformatf("m_we/%0d", k),     32'(m_we[k]),     32'(e_we));
            check_eq($sformatf("m_wmask/%0d", k),  32'(m_wmask[k]),  32'(e_msk));
            check_eq($sformatf("m_addr/%0d", k),   m_addr[k],        e_ma);
            check_eq($sformatf("m_wdata/%0d", k),  m_wdata[k],       e_mwd);
            if (d_ready[k]) ord_q[k].push_back(8'h44);
            if (i_ready[k]) ord_q[k].push_back(8'h49);
            if (i_rvalid[k]) last_i[k] = i_rdata[k];
            if (d_rvalid[k]) last_d[k] = d_rdata[k];
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_d(input logic we, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata);
        for (int k = 0; k < 2; k++) begin
            d_req[k] = 1'b1; d_we[k] = we; d_wmask[k] = mask;
            d_addr[k] = addr; d_wdata[k] = wdata;
        end
    endtask

    task automatic issue_i(input logic [31:0] addr);
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
    endtask

    // drop each request right after the model sees it accepted
    task automatic drain();
        int budget = 40;
        while ((i_req != 2'b00 || d_req != 2'b00) && budget > 0) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (acc_i[k]) i_req[k] = 1'b0;
                if (acc_d[k]) d_req[k] = 1'b0;
            end
            budget--;
        end
        check_eq("drain_budget", 32'(budget > 0), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step();
    endtask

    initial begin
        int base[2];
        total = 0; bad = 0; cyc = 0;
        reset = 1'b0;
        i_req = '0; i_addr = '0; d_req = '0; d_we = '0; d_wmask = '0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; own_d[k] = 1'b0; fav_d[k] = 1'b1; due[k] = 0;
            rdat[k] = '0; acc_i[k] = 1'b0; acc_d[k] = 1'b0; last_i[k] = '0; last_d[k] = '0;
        end
        idle_cycles(3);
        #1 reset = 1'b1;

        // continuous contention straight after reset: D,I,D,I,...
        for (int k = 0; k < 2; k++) base[k] = ord_q[k].size();
        issue_d(1'b0, 4'h0, 32'h20, 32'h0);
        issue_i(32'h10);
        for (int n = 0; n < 60 && (ord_q[0].size() < base[0] + 8 || ord_q[1].size() < base[1] + 8); n++)
            step();
        drain();
        idle_cycles(5);
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++)
                check_eq($sformatf("order/%0d/%0d", k, j), 32'(ord_q[k][base[k] + j]),
                         (j % 2 == 0) ? 32'h44 : 32'h49);

        // instruction read returns to the instruction port
        issue_d(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        drain();
        for (int k = 0; k < 2; k++) last_i[k] = '0;
        issue_i(32'h10);
        drain();
        idle_cycles(5);
        for (int k = 0; k < 2; k++) check_eq($sformatf("ifetch/%0d", k), last_i[k], 32'hDEADBEEF);

        // partial write, then empty-mask write must change nothing
        issue_d(1'b1, 4'b0011, 32'h20, 32'h12345678);
        drain();
        issue_d(1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF);
        drain();
        for (int k = 0; k < 2; k++) last_d[k] = '0;
        issue_d(1'b0, 4'h0, 32'h20, 32'h0);
        drain();
        idle_cycles(5);
        for (int k = 0; k < 2; k++) check_eq($sformatf("masked_wr/%0d", k), last_d[k], 32'h00005678);

        // reset while a read is outstanding
        issue_d(1'b0, 4'h0, 32'h10, 32'h0);
        drain();
        issue_d(1'b0, 4'h0, 32'h20, 32'h0);
        issue_i(32'h30);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_rdy/%0d", k),  32'({i_ready[k], d_ready[k]}), 32'd0);
            check_eq($sformatf("rst_rv/%0d", k),   32'({i_rvalid[k], d_rvalid[k]}), 32'd0);
            check_eq($sformatf("rst_men/%0d", k),  32'(m_en[k]), 32'd0);
            check_eq($sformatf("rst_addr/%0d", k), m_addr[k], 32'd0);
        end
        idle_cycles(2);
        for (int k = 0; k < 2; k++) base[k] = ord_q[k].size();
        #1 reset = 1'b1;
        drain();
        idle_cycles(5);
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("tie_after_rst/%0d", k), 32'(ord_q[k][base[k]]), 32'h44);

        // randomized traffic
        repeat (1500) begin
            for (int k = 0; k < 2; k++) begin
                if (!i_req[k] || acc_i[k]) begin
                    i_req[k]  = ($urandom_range(0, 2) != 0);
                    i_addr[k] = $urandom;
                end
                if (!d_req[k] || acc_d[k]) begin
                    d_req[k]   = ($urandom_range(0, 2) != 0);
                    d_we[k]    = $urandom_range(0, 1) != 0;
                    d_wmask[k] = 4'($urandom_range(0, 15));
                    d_addr[k]  = $urandom;
                    d_wdata[k] = $urandom;
                end
            end
            step();
        end
        drain();
        idle_cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
